// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB3 requester that turns a valid/ready command stream into
// single APB transfers and returns each result on a valid/ready response stream.
// One transfer is outstanding at a time; a PREADY timeout aborts hung transfers.
//
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_write/addr/wdata payload
//   rsp_valid/ready     response handshake; rsp_rdata/err/timeout payload
//   busy                high whenever the FSM is not idle
//   PSEL..PWDATA        APB request signals (registered)
//   PRDATA/PREADY/PSLVERR  APB completion signals from the slave

module apb_cmd_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   // command stream
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   // response stream
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   // APB requester side
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);
   // Last counter value before abort; the counter never wraps past it.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   logic [1:0]        state_q,       state_d;
   logic              psel_q,        psel_d;
   logic              penable_q,     penable_d;
   logic              pwrite_q,      pwrite_d;
   logic [ADDR_W-1:0] paddr_q,       paddr_d;
   logic [DATA_W-1:0] pwdata_q,      pwdata_d;
   logic              rsp_valid_q,   rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
   logic              rsp_err_q,     rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              busy_q,        busy_d;
   logic [CNT_W-1:0]  cnt_q,         cnt_d;

   // Only combinational output: ready exactly when idle and not being reset.
   assign cmd_ready = (state_q == ST_IDLE) & ~PRESET;

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;

      case (state_q)
         ST_IDLE: begin
            // Request signals change only on acceptance; held otherwise.
            if (cmd_valid && cmd_ready) begin
               pwrite_d  = cmd_write;
               paddr_d   = cmd_addr;
               pwdata_d  = cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = ST_SETUP;
            end
         end

         ST_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ACCESS;
         end

         ST_ACCESS: begin
            // PREADY wins over the timeout, so a wait of TIMEOUT cycles still completes.
            if (PREADY) begin
               rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = ST_RESP;
            end else if (cnt_q == CNT_MAX) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any transfer in flight.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q       <= ST_IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         busy_q        <= busy_d;
         cnt_q         <= cnt_d;
      end
   end

   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: scoreboard bench for apb_cmd_master with a reactive APB
// slave (configurable wait states, hang and error) backed by a small memory.

module tb_apb_cmd_master;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   logic          PCLK;
   logic          PRESET;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          busy;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
      logic          to;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          acc_log[$];
   int          total;
   int          bad;
   int          cyc;
   int          hs_cyc;

   // slave model configuration
   int          slv_wait;
   bit          slv_hang;
   bit          slv_err;
   int          acc_k;
   logic [31:0] mem [0:255];

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Cycle count and slave write commit at the completing edge.
   always @(posedge PCLK) begin
      cyc++;
      if (PSEL === 1'b1 && PENABLE === 1'b1 && PREADY === 1'b1 && PWRITE === 1'b1)
         mem[PADDR[9:2]] = PWDATA;
   end

   // Slave drives completion signals mid-cycle for the coming edge.
   always @(negedge PCLK) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
         acc_k++;
         PREADY  = !slv_hang && (acc_k > slv_wait);
         PRDATA  = mem[PADDR[9:2]];
         PSLVERR = slv_err;
      end else begin
         acc_k   = 0;
         PREADY  = 1'b0;
         PRDATA  = '0;
         PSLVERR = 1'b0;
      end
   end

   // Response monitor: pops the scoreboard on every handshake; logs accepts.
   always @(negedge PCLK) begin
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         hs_cyc = cyc;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rsp got rdata=%h err=%b to=%b required no response",
                     rsp_rdata, rsp_err, rsp_timeout);
         end else begin
            e = exp_q.pop_front();
            if (rsp_rdata !== e.rdata) begin
               bad++;
               $display("FAIL rsp_rdata got=%h required=%h", rsp_rdata, e.rdata);
            end
            total++;
            if (rsp_err !== e.err) begin
               bad++;
               $display("FAIL rsp_err got=%b required=%b", rsp_err, e.err);
            end
            total++;
            if (rsp_timeout !== e.to) begin
               bad++;
               $display("FAIL rsp_timeout got=%b required=%b", rsp_timeout, e.to);
            end
         end
      end
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1)
         acc_log.push_back(cyc);
   end

   // Present a command and hold it until accepted; returns just after the accept edge.
   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit ok = 1'b0;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge PCLK);
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge PCLK);
      #1;
      cmd_valid = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL issue_accept got=no_accept required=accept within 200 cycles");
      end
   endtask

   // Observe one transfer starting in SETUP: ACCESS length and request stability.
   task automatic count_access(output int n, output bit setup_ok, output bit stable);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          w;
      n      = 0;
      stable = 1'b1;
      @(negedge PCLK);
      setup_ok = (PSEL === 1'b1 && PENABLE === 1'b0);
      a = PADDR;
      d = PWDATA;
      w = PWRITE;
      for (int i = 0; i < 100; i++) begin
         @(negedge PCLK);
         if (!(PSEL === 1'b1 && PENABLE === 1'b1)) break;
         n++;
         if (PADDR !== a || PWDATA !== d || PWRITE !== w) stable = 1'b0;
      end
   endtask

   // Wait until every expected response has been seen and the DUT is idle.
   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge PCLK);
         if (exp_q.size() == 0 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL drain got pending=%0d busy=%b required pending=0 busy=0",
                  exp_q.size(), busy);
      end
   endtask

   task automatic test_reset();
      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, busy} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b required=0000000",
                  {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, busy});
      end
      total++;
      if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h required all 0",
                  PADDR, PWDATA, rsp_rdata);
      end
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_cmd_ready got=%b required=0", cmd_ready);
      end
      @(posedge PCLK);
      #1;
      PRESET = 1'b0;
      @(negedge PCLK);
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle got ready=%b busy=%b required ready=1 busy=0",
                  cmd_ready, busy);
      end
   endtask

   task automatic test_zero_wait();
      int  n;
      bit  s_ok;
      bit  st;
      int  sz;
      @(posedge PCLK);
      #1;
      slv_wait = 0;
      exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
      exp_q.push_back('{rdata: 32'hAAAA_FFFF, err: 1'b0, to: 1'b0});
      issue(1'b1, 32'h0, 32'hAAAA_FFFF);
      // queue the read right away so it goes out on the first idle cycle
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      cmd_valid = 1'b1;
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE} !== 2'b10 || PADDR !== 32'h0 || PWDATA !== 32'hAAAA_FFFF
          || PWRITE !== 1'b1 || cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL zw_setup got sel/en=%b%b addr=%h wdata=%h wr=%b rdy=%b required 10 0 aaaaffff 1 0",
                  PSEL, PENABLE, PADDR, PWDATA, PWRITE, cmd_ready);
      end
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 32'h0 || PWDATA !== 32'hAAAA_FFFF) begin
         bad++;
         $display("FAIL zw_access got sel/en=%b%b addr=%h wdata=%h required 11 0 aaaaffff",
                  PSEL, PENABLE, PADDR, PWDATA);
      end
      @(negedge PCLK);
      total++;
      if (rsp_valid !== 1'b1 || {PSEL, PENABLE} !== 2'b00) begin
         bad++;
         $display("FAIL zw_resp got valid=%b sel/en=%b%b required 1 00", rsp_valid, PSEL, PENABLE);
      end
      @(negedge PCLK);
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL zw_idle_ready got=%b required=1", cmd_ready);
      end
      @(posedge PCLK);
      #1;
      cmd_valid = 1'b0;
      sz = acc_log.size();
      total++;
      if (sz < 2) begin
         bad++;
         $display("FAIL zw_spacing got accepts=%0d required>=2", sz);
      end else if (acc_log[sz-1] - acc_log[sz-2] != 4) begin
         bad++;
         $display("FAIL zw_spacing got=%0d required=4", acc_log[sz-1] - acc_log[sz-2]);
      end
      count_access(n, s_ok, st);
      total++;
      if (n != 1 || !s_ok || !st) begin
         bad++;
         $display("FAIL zw_read_phases got access=%0d setup=%b stable=%b required 1 1 1", n, s_ok, st);
      end
      wait_drain();
   endtask

   task automatic test_wait_states();
      int n;
      bit s_ok;
      bit st;
      @(posedge PCLK);
      #1;
      mem[8'h10] = 32'hABFE_FABE;
      slv_wait   = 3;
      exp_q.push_back('{rdata: 32'hABFE_FABE, err: 1'b0, to: 1'b0});
      issue(1'b0, 32'h40, 32'h0);
      count_access(n, s_ok, st);
      total++;
      if (n != 4 || !s_ok || !st) begin
         bad++;
         $display("FAIL wait_access got access=%0d setup=%b stable=%b required 4 1 1", n, s_ok, st);
      end
      wait_drain();
      slv_wait = 0;
   endtask

   task automatic test_timeout();
      int n;
      bit s_ok;
      bit st;
      @(posedge PCLK);
      #1;
      mem[8'h20] = 32'h7777_7777;
      slv_hang   = 1'b1;
      exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
      issue(1'b0, 32'h80, 32'h0);
      count_access(n, s_ok, st);
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL timeout_len got=%0d required=16", n);
      end
      wait_drain();
      slv_hang = 1'b0;
      // PREADY on the last allowed ACCESS cycle completes normally
      @(posedge PCLK);
      #1;
      mem[8'h21] = 32'h1234_5678;
      slv_wait   = 15;
      exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, to: 1'b0});
      issue(1'b0, 32'h84, 32'h0);
      count_access(n, s_ok, st);
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL timeout_boundary_len got=%0d required=16", n);
      end
      wait_drain();
      slv_wait = 0;
   endtask

   task automatic test_slave_error();
      @(posedge PCLK);
      #1;
      mem[8'h30] = 32'hDEAD_BEEF;
      slv_err    = 1'b1;
      exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b1, to: 1'b0});
      issue(1'b0, 32'hC0, 32'h0);
      wait_drain();
      slv_err = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok = 1'b0;
      int sz;
      @(posedge PCLK);
      #1;
      rsp_ready = 1'b0;
      exp_q.push_back('{rdata: 32'hABFE_FABE, err: 1'b0, to: 1'b0});
      exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
      issue(1'b0, 32'h40, 32'h0);
      cmd_write = 1'b1;
      cmd_addr  = 32'h100;
      cmd_wdata = 32'h5555_0000;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (rsp_valid === 1'b1) break;
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge PCLK);
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hABFE_FABE) begin
            bad++;
            $display("FAIL bp_hold[%0d] got valid=%b rdata=%h required 1 abfefabe", i, rsp_valid, rsp_rdata);
         end
         total++;
         if (cmd_ready !== 1'b0 || PSEL !== 1'b0) begin
            bad++;
            $display("FAIL bp_blocked[%0d] got ready=%b psel=%b required 0 0", i, cmd_ready, PSEL);
         end
      end
      @(posedge PCLK);
      #1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge PCLK);
      #1;
      cmd_valid = 1'b0;
      sz = acc_log.size();
      total++;
      if (!ok || sz == 0 || acc_log[sz-1] - hs_cyc != 1) begin
         bad++;
         $display("FAIL bp_next_accept got accepted=%b gap=%0d required 1 1",
                  ok, (sz == 0) ? -1 : acc_log[sz-1] - hs_cyc);
      end
      wait_drain();
   endtask

   task automatic test_reset_mid_access();
      int seen = 0;
      @(posedge PCLK);
      #1;
      slv_wait = 10;
      issue(1'b0, 32'h40, 32'h0);
      repeat (3) @(negedge PCLK);
      @(posedge PCLK);
      #1;
      PRESET = 1'b1;
      @(posedge PCLK);
      #1;
      PRESET = 1'b0;
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, rsp_valid, busy} !== 4'b0000) begin
         bad++;
         $display("FAIL rst_abort got sel/en/valid/busy=%b required 0000",
                  {PSEL, PENABLE, rsp_valid, busy});
      end
      slv_wait = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (rsp_valid === 1'b1) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL rst_no_rsp got=%0d required=0", seen);
      end
      @(posedge PCLK);
      #1;
      exp_q.push_back('{rdata: 32'hABFE_FABE, err: 1'b0, to: 1'b0});
      issue(1'b0, 32'h40, 32'h0);
      wait_drain();
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      cyc      = 0;
      hs_cyc   = 0;
      slv_wait = 0;
      slv_hang = 1'b0;
      slv_err  = 1'b0;
      acc_k    = 0;
      PREADY   = 1'b0;
      PRDATA   = '0;
      PSLVERR  = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_timeout();
      test_slave_error();
      test_backpressure();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB3 requester: converts a simple valid/ready command stream into single APB transfers, and returns each result on a valid/ready response stream.
- Sits between an on-chip controller (CPU bridge or test sequencer) and the GPIO APB slave. It drives PSEL, PENABLE, PWRITE, PADDR and PWDATA, and samples PRDATA, PREADY and PSLVERR.
- One transfer is outstanding at a time. A PREADY timeout keeps a hung slave from stalling the controller.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, maximum ACCESS-phase cycles with PREADY low before the transfer is aborted. Legal range 2..65535.

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR was sampled high or a timeout occurred.
- rsp_timeout  out  1  the transfer was aborted by timeout.
- busy  out  1  state != IDLE.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error; tie to 0 for slaves that do not drive it.

Behaviour:
- Reset (PRESET high at a PCLK edge):
  - state becomes IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout and busy are 0.
  - PADDR, PWDATA and rsp_rdata are 0.
  - The timeout counter is 0.
  - Reset mid-transfer aborts it: PSEL and PENABLE are low from the cycle after the reset edge, and no response is produced.
- All outputs are registered. cmd_ready is the only output decoded from state: cmd_ready = (state == IDLE) & ~PRESET.
- IDLE:
  - On cmd_valid & cmd_ready, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
  - PSEL = 0 and PENABLE = 0 in this state.
- SETUP (exactly one cycle):
  - PSEL = 1, PENABLE = 0.
  - Go to ACCESS; clear the timeout counter.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS.
  - If PREADY = 1 at the edge:
    - rsp_rdata = PWRITE ? 0 : PRDATA.
    - rsp_err = PSLVERR; rsp_timeout = 0.
    - Go to RESP.
  - Else if counter == TIMEOUT-1:
    - rsp_rdata = 0; rsp_err = 1; rsp_timeout = 1.
    - Go to RESP.
  - Else increment the counter.
  - A transfer that sees PREADY in ACCESS cycle k (k = 1..TIMEOUT) completes normally, including PREADY on exactly cycle TIMEOUT. A timeout therefore takes exactly TIMEOUT ACCESS cycles.
- RESP:
  - PSEL = 0, PENABLE = 0; rsp_valid = 1.
  - rsp_rdata, rsp_err and rsp_timeout are held until rsp_ready = 1.
  - On the handshake edge, rsp_valid drops and state goes to IDLE.
- PADDR, PWDATA and PWRITE keep their last values while idle. They change only on command acceptance.
- Latency with zero-wait slave and rsp_ready held high:
  - accept edge → SETUP for 1 cycle → ACCESS for 1 cycle → rsp_valid for 1 cycle → IDLE.
  - Peak throughput is one transfer per 4 cycles.
- Commands are not accepted in SETUP, ACCESS or RESP. cmd_valid may stay high; the command is accepted on the first IDLE cycle.
- PREADY and PSLVERR are ignored outside ACCESS.
- The timeout counter width is $clog2(TIMEOUT). The counter never wraps, because it leaves ACCESS at TIMEOUT-1.

Test Plan:
- Write then read, zero-wait slave (PREADY tied 1):
  - Stimulus: write 0x0000_0000 data 0xAAAA_FFFF, then read the same address.
  - Required: PSEL/PENABLE show one SETUP cycle then one ACCESS cycle per transfer; PADDR and PWDATA are stable across both; the write response has rsp_rdata = 0, rsp_err = 0; the read response has rsp_rdata = 0xAAAA_FFFF; transfers are 4 cycles apart.
- Wait states:
  - Stimulus: slave holds PREADY low for 3 ACCESS cycles, then returns PRDATA = 0xABFE_FABE.
  - Required: ACCESS lasts 4 cycles with signals stable throughout; rsp_rdata = 0xABFE_FABE; rsp_err = 0.
- Timeout, with TIMEOUT = 16:
  - Stimulus: PREADY stuck low.
  - Required: exactly 16 ACCESS cycles, then rsp_valid with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Boundary case: PREADY arriving on ACCESS cycle 16 gives a normal completion with rsp_timeout = 0.
- Slave error:
  - Stimulus: PSLVERR = 1 together with PREADY on a read.
  - Required: rsp_err = 1, rsp_timeout = 0, rsp_rdata = sampled PRDATA.
- Response backpressure:
  - Stimulus: hold rsp_ready low for 5 cycles after a read, with cmd_valid high for the next command.
  - Required: rsp_valid and rsp_rdata are stable for those 5 cycles; cmd_ready stays 0 and PSEL stays 0; the next command is accepted in the first IDLE cycle after the handshake.
- Reset mid-ACCESS:
  - Stimulus: assert PRESET for one cycle during a wait-stated read.
  - Required: next cycle PSEL = PENABLE = 0, rsp_valid = 0, busy = 0; no response is ever emitted for the aborted read; the following command completes normally.
